pixel_scan_sequencer: RTL and testbench

Frame-level driver for the single-bounce raytracer core. It walks the screen in raster order and issues one pixel coordinate at a time on the core's pixel request interface. It collects each returned RGB result and forwards it, tagged with coordinates and frame markers, on a valid/ready stream to the downstream framebuffer or display writer. It also detects a core that stops responding and substitutes background colour so a frame always completes.

---
 rtl/raster_pkg.sv | 28 ++
 rtl/raster_counter.sv | 53 +++++
 rtl/pixel_scan_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : raster_pkg
//  Purpose  : Shared constants and types for the pixel scan sequencer:
//             default screen geometry, background colour and FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package raster_pkg;

    // Default screen geometry
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // Background colour, identical to what the raytracer emits for a miss
    localparam logic [7:0] BG_R = 8'd0;
    localparam logic [7:0] BG_G = 8'd0;
    localparam logic [7:0] BG_B = 8'd32;

    // Sequencer states, 3-bit encoding kept as plain constants
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage : raster_pkg
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : raster_counter
//  Purpose  : Raster-order x/y position register with advance and
//             synchronous clear, plus start/end-of-line/end-of-frame flags.
//  Revision : 1.0  initial release
// ============================================================================
module raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       is_sof,
    output logic       is_eol,
    output logic       is_eof
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    // Position register: advancing past the last pixel wraps back to (0,0)
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + 9'd1;
                end
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    // Position flags decoded from the current coordinate
    always_comb begin
        is_sof = (x == '0) && (y == '0);
        is_eol = (x == X_LAST);
        is_eof = (x == X_LAST) && (y == Y_LAST);
    end

endmodule : raster_counter
`default_nettype wire

// File: rtl/pixel_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_scan_sequencer
//  Purpose  : Walks the screen in raster order, issues one pixel request at a
//             time to the raytracer core, collects the colour (or substitutes
//             background after a timeout) and forwards it as a tagged
//             valid/ready stream beat.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_scan_sequencer
    import raster_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic       pixel_valid,
    input  logic [7:0] rt_r,
    input  logic [7:0] rt_g,
    input  logic [7:0] rt_b,
    input  logic       rt_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic [9:0] out_x,
    output logic [8:0] out_y,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic       timeout_err,
    output logic       proto_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic       is_sof;
    logic       is_eol;
    logic       is_eof;
    logic       start_accept;
    logic       handshake;
    logic       timeout_hit;
    logic       rt_capture;

    // Event decode shared by the state machine and datapath
    always_comb begin
        start_accept = (state == ST_IDLE) && start;
        handshake    = (state == ST_EMIT) && out_ready;
        rt_capture   = (state == ST_WAIT) && rt_valid;
        // A result arriving in the expiry cycle still wins over the timeout
        timeout_hit  = (state == ST_WAIT) && !rt_valid && (wait_cnt == TIMEOUT_LAST);
    end

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_accept),
        .advance (handshake),
        .x       (cur_x),
        .y       (cur_y),
        .is_sof  (is_sof),
        .is_eol  (is_eol),
        .is_eof  (is_eof)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rt_capture || timeout_hit) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt = is_eof ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control outputs registered from the next state so none of them
    // depends combinationally on an input
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            pixel_valid <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            busy        <= (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT) ||
                           (state_nxt == ST_EMIT);
            frame_done  <= (state_nxt == ST_DONE);
            pixel_valid <= (state_nxt == ST_ISSUE);
            out_valid   <= (state_nxt == ST_EMIT);
        end
    end

    // Response wait counter: restarts on every request
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !rt_valid && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Colour hold register: raytracer result or background on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= BG_R;
            out_g <= BG_G;
            out_b <= BG_B;
        end else if (rt_capture) begin
            out_r <= rt_r;
            out_g <= rt_g;
            out_b <= rt_b;
        end else if (timeout_hit) begin
            out_r <= BG_R;
            out_g <= BG_G;
            out_b <= BG_B;
        end
    end

    // Sticky error flags, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (start_accept) begin
                timeout_err <= 1'b0;
            end
            // A stray strobe is recorded even if it coincides with start
            if (rt_valid && (state != ST_WAIT)) begin
                proto_err <= 1'b1;
            end else if (start_accept) begin
                proto_err <= 1'b0;
            end
        end
    end

    // Coordinates follow the position register, which only moves on a
    // handshake, so beat fields are stable while a beat is stalled
    always_comb begin
        pixel_x = cur_x;
        pixel_y = cur_y;
        out_x   = cur_x;
        out_y   = cur_y;
        out_sof = out_valid && is_sof;
        out_eol = out_valid && is_eol;
        out_eof = out_valid && is_eof;
    end

endmodule : pixel_scan_sequencer
`default_nettype wire

// File: tb/tb_pixel_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_scan_sequencer
//  Purpose  : Self-checking bench for pixel_scan_sequencer on a 4x2 screen
//             with a 3-cycle raytracer responder model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_scan_sequencer;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          TO   = 15;
    localparam int          NPIX = H * V;
    localparam logic [23:0] BG   = 24'h000020;

    logic       clk = 1'b0;
    logic       rst, start, rt_valid, out_ready;
    logic [7:0] rt_r, rt_g, rt_b;
    logic       busy, frame_done, pixel_valid, out_valid;
    logic [9:0] pixel_x, out_x;
    logic [8:0] pixel_y, out_y;
    logic [7:0] out_r, out_g, out_b;
    logic       out_sof, out_eol, out_eof, timeout_err, proto_err;

    always #5 clk = ~clk;

    pixel_scan_sequencer #(
        .H_RES       (H),
        .V_RES       (V),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .frame_done  (frame_done),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .rt_r        (rt_r),
        .rt_g        (rt_g),
        .rt_b        (rt_b),
        .rt_valid    (rt_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Per-frame scenario configuration
    bit          drop [NPIX];
    logic [23:0] col  [NPIX];
    int          stall_idx, stall_len, abort_idx;
    bit          emit_pulse, hold_start;

    typedef struct {
        int drop_idx;
        int stall_idx;
        int stall_len;
        bit emit_pulse;
        bit exp_terr;
        bit exp_perr;
        int exp_cycles;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected beat for raster index i: coordinates, flags and colour
    function automatic logic [45:0] exp_beat(input int i);
        int          bx, by;
        logic [23:0] c;
        bx = i % H;
        by = i / H;
        c  = drop[i] ? BG : col[i];
        return {10'(bx), 9'(by), (i == 0), (bx == H - 1), (i == NPIX - 1), c};
    endfunction

    task automatic check_reset_state(input string name);
        chk({name, "_ctl"},
            {busy, frame_done, pixel_valid, out_valid, out_sof, out_eol, out_eof,
             timeout_err, proto_err, pixel_x, pixel_y, out_x, out_y},
            47'd0);
        chk({name, "_rgb"}, {out_r, out_g, out_b}, BG);
    endtask

    // Runs one frame from IDLE; the responder answers 3 cycles after each
    // request unless the pixel is marked dropped
    task automatic run_frame(output int frame_cycles, output int beats,
                             output logic terr, output logic perr);
        int issued      = 0;
        int first_issue = -1;
        int due         = -1;
        int due_idx     = 0;
        int issue_cyc   = 0;
        int abort_at    = -1;
        int stalls_left = stall_len;
        int budget      = 0;
        bit pulsed      = 0;
        bit done        = 0;
        bit beat_seen   = 0;
        frame_cycles = -1;
        beats        = 0;
        terr         = 1'b0;
        perr         = 1'b0;
        start        = 1'b1;
        while (!done && budget < 1000) begin
            tick();
            budget++;
            start     = hold_start;
            rt_valid  = 1'b0;
            out_ready = 1'b1;
            if (cyc == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                tick();
                rst = 1'b0;
                check_reset_state("abort_reset");
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("abort_no_done", {frame_done, busy}, 2'b00);
                end
                frame_cycles = -2;
                return;
            end
            if (pixel_valid) begin
                chk("issue_xy", {pixel_x, pixel_y}, {10'(issued % H), 9'(issued / H)});
                chk("issue_order", issued, beats);
                if (first_issue < 0) first_issue = cyc;
                issue_cyc = cyc;
                due       = cyc + 3;
                due_idx   = issued;
                if (issued == abort_idx) abort_at = cyc + 1;
                issued++;
            end
            if (due == cyc && !drop[due_idx]) begin
                rt_valid = 1'b1;
                {rt_r, rt_g, rt_b} = col[due_idx];
            end
            if (out_valid) begin
                if (!beat_seen) begin
                    chk("beat_latency", cyc - issue_cyc, (beats < NPIX && drop[beats]) ? TO + 2 : 4);
                    beat_seen = 1;
                end
                if (beats == stall_idx && stalls_left > 0) begin
                    out_ready = 1'b0;
                    stalls_left--;
                    if (emit_pulse && !pulsed) begin
                        rt_valid = 1'b1;
                        {rt_r, rt_g, rt_b} = ~col[beats];
                        pulsed = 1;
                    end
                end
                if (beats < NPIX) begin
                    chk("beat", {out_x, out_y, out_sof, out_eol, out_eof, out_r, out_g, out_b},
                        exp_beat(beats));
                end else begin
                    chk("extra_beat", 1, 0);
                end
                if (out_ready) begin
                    beats++;
                    beat_seen = 0;
                end
            end
            if (frame_done) begin
                frame_cycles = cyc - first_issue;
                terr         = timeout_err;
                perr         = proto_err;
                chk("done_busy_low", busy, 1'b0);
                done = 1;
            end
        end
        if (!done) chk("frame_completed", 0, 1);
        start     = hold_start;
        rt_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NPIX; i++) begin
            drop[i] = 0;
            col[i]  = 24'($urandom);
        end
        stall_idx  = -1;
        stall_len  = 0;
        abort_idx  = -1;
        emit_pulse = 0;
        hold_start = 0;
    endtask

    task automatic check_frame(input string name, input int fc, input int bt,
                               input logic te, input logic pe,
                               input int exp_fc, input logic exp_te, input logic exp_pe);
        chk({name, "_cycles"}, fc, exp_fc);
        chk({name, "_beats"}, bt, NPIX);
        chk({name, "_flags"}, {te, pe}, {exp_te, exp_pe});
    endtask

    initial begin
        int   fc, bt, nd, exp_fc;
        logic te, pe;

        rst = 1'b1; start = 1'b0; rt_valid = 1'b0; out_ready = 1'b1;
        rt_r = '0; rt_g = '0; rt_b = '0;
        clear_cfg();
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("por");
        tick();

        // drop, stall idx, stall len, emit pulse, timeout_err, proto_err, cycles
        tbl[0] = '{-1, -1, 0, 0, 0, 0, 40};
        tbl[1] = '{-1,  2, 7, 0, 0, 0, 47};
        tbl[2] = '{ 1, -1, 0, 0, 1, 0, 53};
        tbl[3] = '{-1,  5, 3, 1, 0, 1, 43};
        tbl[4] = '{ 7,  0, 2, 0, 1, 0, 55};
        for (int i = 0; i < 5; i++) begin
            clear_cfg();
            if (tbl[i].drop_idx >= 0) drop[tbl[i].drop_idx] = 1;
            stall_idx  = tbl[i].stall_idx;
            stall_len  = tbl[i].stall_len;
            emit_pulse = tbl[i].emit_pulse;
            run_frame(fc, bt, te, pe);
            check_frame("tbl", fc, bt, te, pe, tbl[i].exp_cycles, tbl[i].exp_terr, tbl[i].exp_perr);
            tick();
        end

        // Stray strobe while idle sets proto_err; the next start clears it
        clear_cfg();
        rt_valid = 1'b1;
        {rt_r, rt_g, rt_b} = 24'hABCDEF;
        tick();
        rt_valid = 1'b0;
        chk("idle_proto_err", {proto_err, out_valid, busy}, 3'b100);
        tick();
        run_frame(fc, bt, te, pe);
        check_frame("after_idle_proto", fc, bt, te, pe, 40, 1'b0, 1'b0);
        tick();

        // Reset during WAIT of pixel (2,1), then a clean restart
        clear_cfg();
        abort_idx = 1 * H + 2;
        run_frame(fc, bt, te, pe);
        chk("abort_path", fc, -2);
        clear_cfg();
        run_frame(fc, bt, te, pe);
        check_frame("restart", fc, bt, te, pe, 40, 1'b0, 1'b0);
        tick();

        // Start held high: one frame, then a fresh frame only via IDLE
        clear_cfg();
        hold_start = 1;
        run_frame(fc, bt, te, pe);
        check_frame("hold_start", fc, bt, te, pe, 40, 1'b0, 1'b0);
        tick();
        chk("hold_idle", {pixel_valid, busy, frame_done}, 3'b000);
        tick();
        chk("hold_reissue", {pixel_valid, pixel_x, pixel_y}, {1'b1, 19'd0});
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("hold_reset");
        tick();

        // Randomized frames against the arithmetic frame model
        for (int f = 0; f < 20; f++) begin
            clear_cfg();
            nd = 0;
            for (int i = 0; i < NPIX; i++) begin
                drop[i] = ($urandom_range(0, 4) == 0);
                if (drop[i]) nd++;
            end
            stall_idx  = int'($urandom_range(0, NPIX - 1));
            stall_len  = int'($urandom_range(0, 6));
            emit_pulse = (stall_len > 0) && ($urandom_range(0, 1) == 1);
            exp_fc     = NPIX * 5 + nd * (TO - 2) + stall_len;
            run_frame(fc, bt, te, pe);
            check_frame("rand", fc, bt, te, pe, exp_fc, nd > 0, emit_pulse);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pixel_scan_sequencer
`default_nettype wire
